distribute_1xn_seq: RTL and testbench



---
 rtl/distribute_1xn_seq_pkg.sv | 32 +++
 rtl/distribute_1xn_seq_out_slot.sv | 47 ++++
 rtl/distribute_1xn_seq.sv | 69 ++++++
 tb/tb_distribute_1xn_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/distribute_1xn_seq_pkg.sv
// Shared definitions for the 1xN registered distribute switch.
// Holds default sizes, the per-slot next-state operation and the port-slice helper.
// Imported by the top level and the output-slot register.
package distribute_1xn_seq_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_OUTPUT = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  // What an output slot does on the next rising edge
  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_DRAIN = 2'd2
  } slot_op_e;

  // A load beats a drain, so a slot emptying this cycle can take a new beat with no bubble
  function automatic slot_op_e slot_op(input logic load, input logic drain);
    if (load) begin
      return SLOT_LOAD;
    end else if (drain) begin
      return SLOT_DRAIN;
    end
    return SLOT_HOLD;
  endfunction

  // LSB position of output port 'port' within the flattened output data bus
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/distribute_1xn_seq_out_slot.sv
// One-entry output register slot: holds one beat for one output port.
// Latency: a load appears on valid/data on the next rising edge.
// Backpressure: data is held while valid && !ready; slot is free when empty or draining.
module distribute_out_slot
  import distribute_1xn_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  free
);

  logic drain;

  assign drain = valid && ready;
  assign free  = !valid || ready;

  // Slot register: load wins over drain; a drained slot returns to all-zero dummy data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      case (slot_op(load, drain))
        SLOT_LOAD: begin
          valid <= 1'b1;
          data  <= load_data;
        end
        SLOT_DRAIN: begin
          valid <= 1'b0;
          data  <= '0;
        end
        default: begin
          valid <= valid;
          data  <= data;
        end
      endcase
    end
  end

endmodule

// File: rtl/distribute_1xn_seq.sv
// Registered 1xN distribute switch: steers each input beat to a bitmask-selected set of outputs.
// Latency: one cycle from accept to the selected outputs' valid.
// Backpressure: o_ready drops unless every selected slot is free; multicast is all-or-nothing.
module distribute_1xn_seq
  import distribute_1xn_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_OUTPUT = DEF_NUM_OUTPUT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [DATA_WIDTH-1:0]            i_data_bus,
  input  logic [NUM_OUTPUT-1:0]            i_cmd,
  input  logic                             i_en,
  output logic [NUM_OUTPUT-1:0]            o_valid,
  input  logic [NUM_OUTPUT-1:0]            i_ready,
  output logic [NUM_OUTPUT*DATA_WIDTH-1:0] o_data_bus,
  output logic [CNT_WIDTH-1:0]             o_drop_cnt
);

  localparam logic [NUM_OUTPUT-1:0] CMD_NONE = '0;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  logic [NUM_OUTPUT-1:0] slot_free;
  logic [NUM_OUTPUT-1:0] blocked;
  logic [NUM_OUTPUT-1:0] slot_load;
  logic                  accept;
  logic                  drop;

  // A selected port that is still occupied and not draining stalls the whole beat.
  // o_ready never looks at i_valid, so there is no valid-to-ready combinational path.
  assign blocked = i_cmd & ~slot_free;
  assign o_ready = rst_n && i_en && (blocked == '0);
  assign accept  = i_valid && o_ready;
  assign drop    = accept && (i_cmd == CMD_NONE);

  genvar k;
  generate
    for (k = 0; k < NUM_OUTPUT; k++) begin : g_slot
      assign slot_load[k] = accept && i_cmd[k];

      distribute_out_slot #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (slot_load[k]),
        .load_data (i_data_bus),
        .ready     (i_ready[k]),
        .valid     (o_valid[k]),
        .data      (o_data_bus[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
        .free      (slot_free[k])
      );
    end
  endgenerate

  // Saturating count of accepted beats that had no destination
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_drop_cnt <= '0;
    end else if (drop && (o_drop_cnt != CNT_MAX)) begin
      o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_distribute_1xn_seq.sv
module tb_distribute_1xn_seq;

  localparam int DW = 32;
  localparam int NO = 4;
  localparam int CW = 16;
  localparam int VW = 1 + NO + NO * DW + CW + 2;

  logic             clk;
  logic             rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [DW-1:0]    i_data_bus;
  logic [NO-1:0]    i_cmd;
  logic             i_en;
  logic [NO-1:0]    o_valid;
  logic [NO-1:0]    i_ready;
  logic [NO*DW-1:0] o_data_bus;
  logic [CW-1:0]    o_drop_cnt;

  // Second instance with a 2-bit counter, driven by the same inputs, for saturation
  logic             o_ready2;
  logic [NO-1:0]    o_valid2;
  logic [NO*DW-1:0] o_data_bus2;
  logic [1:0]       o_drop_cnt2;

  int n_tests;
  int n_fail;

  // Reference model: per-port occupancy and payload, plus total drop count
  bit            m_vld [NO];
  logic [DW-1:0] m_dat [NO];
  int            m_drops;

  distribute_1xn_seq #(.DATA_WIDTH(DW), .NUM_OUTPUT(NO), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_bus(i_data_bus), .i_cmd(i_cmd), .i_en(i_en), .o_valid(o_valid),
    .i_ready(i_ready), .o_data_bus(o_data_bus), .o_drop_cnt(o_drop_cnt)
  );

  distribute_1xn_seq #(.DATA_WIDTH(DW), .NUM_OUTPUT(NO), .CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready2),
    .i_data_bus(i_data_bus), .i_cmd(i_cmd), .i_en(i_en), .o_valid(o_valid2),
    .i_ready(i_ready), .o_data_bus(o_data_bus2), .o_drop_cnt(o_drop_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_ready();
    logic r;
    r = rst_n && i_en;
    for (int k = 0; k < NO; k++)
      if (i_cmd[k] && m_vld[k] && !i_ready[k]) r = 1'b0;
    return r;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [NO-1:0]    v;
    logic [NO*DW-1:0] b;
    logic [CW-1:0]    c;
    logic [1:0]       c2;
    for (int k = 0; k < NO; k++) begin
      v[k]         = m_vld[k];
      b[k*DW +: DW] = m_dat[k];
    end
    c  = (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
    c2 = (m_drops > 3) ? 2'd3 : 2'(m_drops);
    return {model_ready(), v, b, c, c2};
  endfunction

  function automatic logic [VW-1:0] got_vec();
    return {o_ready, o_valid, o_data_bus, o_drop_cnt, o_drop_cnt2};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NO; k++) begin
      m_vld[k] = 1'b0;
      m_dat[k] = '0;
    end
    m_drops = 0;
  endtask

  // Apply the switching rules to the inputs present at the coming edge, then advance one cycle
  task automatic advance();
    logic acc;
    acc = i_valid && model_ready();
    for (int k = 0; k < NO; k++) begin
      if (acc && i_cmd[k]) begin
        m_vld[k] = 1'b1;
        m_dat[k] = i_data_bus;
      end else if (m_vld[k] && i_ready[k]) begin
        m_vld[k] = 1'b0;
        m_dat[k] = '0;
      end
    end
    if (acc && i_cmd == '0) m_drops++;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [NO-1:0] c, input logic [DW-1:0] d,
                       input logic [NO-1:0] r, input logic e);
    i_valid = v; i_cmd = c; i_data_bus = d; i_ready = r; i_en = e;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1'b1, 4'b0000, 32'h0, 4'b1111, 1'b1);
    @(negedge clk); #1;
    n_tests++;
    if (got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", got_vec(), exp_vec());
    end
    n_tests++;
    if (o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=0", o_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
  endtask

  task automatic test_unicast();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 4'b0010, 32'hA0 + i, 4'b1111, 1'b1);
      else       drive(1'b0, 4'b0010, 32'h0, 4'b1111, 1'b1);
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL unicast_cyc%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      if (i >= 1 && i <= 8) begin
        n_tests++;
        if (o_valid !== 4'b0010 || o_data_bus[DW +: DW] !== 32'hA0 + i - 1 || o_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL unicast_port1_cyc%0d got vld=%b dat=%h rdy=%b exp vld=0010 dat=%h rdy=1",
                   i, o_valid, o_data_bus[DW +: DW], o_ready, 32'hA0 + i - 1);
        end
      end
      advance();
    end
  endtask

  task automatic test_bcast_stall();
    drive(1'b1, 4'b1111, 32'h55, 4'b1011, 1'b1);
    advance();
    for (int i = 0; i < 5; i++) begin
      if (i < 3)       drive(1'b1, 4'b1111, 32'h66, 4'b1011, 1'b1);
      else if (i == 3) drive(1'b1, 4'b1111, 32'h66, 4'b1111, 1'b1);
      else             drive(1'b0, 4'b1111, 32'h0, 4'b0000, 1'b1);
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bcast_cyc%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      if (i >= 1 && i < 3) begin
        n_tests++;
        if (o_ready !== 1'b0 || o_valid !== 4'b0100 || o_data_bus[2*DW +: DW] !== 32'h55) begin
          n_fail++;
          $display("FAIL bcast_hold_cyc%0d got rdy=%b vld=%b p2=%h exp rdy=0 vld=0100 p2=55",
                   i, o_ready, o_valid, o_data_bus[2*DW +: DW]);
        end
      end
      if (i == 4) begin
        n_tests++;
        if (o_valid !== 4'b1111 || o_data_bus !== {4{32'h66}}) begin
          n_fail++;
          $display("FAIL bcast_second got vld=%b bus=%h exp vld=1111 bus=all 66", o_valid, o_data_bus);
        end
      end
      advance();
    end
    drive(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
    advance();
  endtask

  task automatic test_independent();
    drive(1'b1, 4'b0001, 32'h11, 4'b1110, 1'b1);
    advance();
    drive(1'b1, 4'b1000, 32'h22, 4'b1110, 1'b1);
    n_tests++;
    if (o_ready !== 1'b1 || got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL indep_accept got=%h exp=%h", got_vec(), exp_vec());
    end
    advance();
    drive(1'b0, 4'b0000, 32'h0, 4'b0110, 1'b1);
    n_tests++;
    if (o_valid !== 4'b1001 || o_data_bus[0 +: DW] !== 32'h11 || o_data_bus[3*DW +: DW] !== 32'h22) begin
      n_fail++;
      $display("FAIL indep_ports got vld=%b p0=%h p3=%h exp vld=1001 p0=11 p3=22",
               o_valid, o_data_bus[0 +: DW], o_data_bus[3*DW +: DW]);
    end
    advance();
    drive(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
    advance();
    n_tests++;
    if (got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL indep_drained got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_drain_load();
    drive(1'b1, 4'b0010, 32'h01, 4'b1111, 1'b1);
    advance();
    drive(1'b1, 4'b0010, 32'h02, 4'b1111, 1'b1);
    n_tests++;
    if (o_ready !== 1'b1 || o_valid !== 4'b0010 || o_data_bus[DW +: DW] !== 32'h01) begin
      n_fail++;
      $display("FAIL dl_offer got rdy=%b vld=%b p1=%h exp rdy=1 vld=0010 p1=01",
               o_ready, o_valid, o_data_bus[DW +: DW]);
    end
    advance();
    drive(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
    n_tests++;
    if (o_valid !== 4'b0010 || o_data_bus[DW +: DW] !== 32'h02) begin
      n_fail++;
      $display("FAIL dl_no_bubble got vld=%b p1=%h exp vld=0010 p1=02", o_valid, o_data_bus[DW +: DW]);
    end
    advance();
  endtask

  task automatic test_drop_enable();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0000, $urandom, 4'b1111, (i < 3));
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL drop_cyc%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      advance();
    end
    drive(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b0);
    n_tests++;
    if (o_drop_cnt !== 16'd3 || o_valid !== 4'b0000 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_en_off got cnt=%0d vld=%b rdy=%b exp cnt=3 vld=0000 rdy=0",
               o_drop_cnt, o_valid, o_ready);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b0000, 32'h0, 4'b1111, 1'b1);
      advance();
    end
    drive(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
    n_tests++;
    if (o_drop_cnt !== 16'd5 || o_drop_cnt2 !== 2'd3 || got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL drop_saturate got cnt=%0d cnt2=%0d exp cnt=5 cnt2=3", o_drop_cnt, o_drop_cnt2);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'b0101, 32'h77, 4'b0000, 1'b1);
    advance();
    drive(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b1);
    n_tests++;
    if (o_valid !== 4'b0101) begin
      n_fail++;
      $display("FAIL rmid_setup got vld=%b exp vld=0101", o_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (got_vec() !== {VW{1'b0}}) begin
      n_fail++;
      $display("FAIL rmid_async got=%h exp=0", got_vec());
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL rmid_release got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [NO-1:0] c;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       c = 4'b0000;
        1:       c = 4'b1111;
        default: c = 4'($urandom);
      endcase
      drive(1'($urandom), c, $urandom, 4'($urandom | $urandom), ($urandom_range(0, 7) != 0));
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cyc%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_unicast();
    test_bcast_stall();
    test_independent();
    test_drain_load();
    test_drop_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
